demux_2_64bit_buf: RTL
======================

// Module: demux_2_64bit_buf
// PURPOSE
//   Registered 1-to-2 demultiplexer with valid/ready handshake and a small FIFO per output.
//   It is the steering counterpart of the 2:1 64-bit select mux. A single producer (e.g. EX/MEM
//   result path) is routed by SEL to one of two consumers (e.g. register-file writeback vs. store buffer).
//   The per-output buffers absorb consumer backpressure, so a stall on one path does not block the other.
// PARAMETERS
//   WIDTH   64   data width in bits
//   DEPTH   2    entries per output FIFO; power of 2, 1..16
// PORTS
//   CLK         in   1      clock, all state on rising edge
//   RST_N       in   1      asynchronous, active-low reset
//   IN          in   WIDTH  input data word
//   IN_VALID    in   1      IN/SEL hold a word to transfer
//   SEL         in   1      destination: 0 -> OUT0, 1 -> OUT1
//   IN_READY    out  1      selected output FIFO can accept a word
//   OUT0        out  WIDTH  head word of FIFO 0
//   OUT0_VALID  out  1      FIFO 0 non-empty
//   OUT0_READY  in   1      consumer 0 accepts OUT0
//   OUT1        out  WIDTH  head word of FIFO 1
//   OUT1_VALID  out  1      FIFO 1 non-empty
//   OUT1_READY  in   1      consumer 1 accepts OUT1
//   STAT0/STAT1 out  32     words accepted into FIFO 0/1 (see CONFIGURATION)
//   STALL_CNT   out  32     cycles with IN_VALID && !IN_READY (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (RST_N low, async assert, sync-to-CLK deassert by system): FIFOs empty, pointers/counts 0,
//     OUTx_VALID=0, OUTx=0, stats=0. A reset mid-transfer discards all buffered words.
//   - Push i: IN_VALID && IN_READY && SEL==i. IN_READY = !full[SEL] (combinational from SEL and state).
//     SEL is don't-care while IN_VALID=0.
//   - Pop i: OUTi_VALID && OUTi_READY; the head advances on that edge.
//   - Latency: a word pushed at edge N is visible on OUTi/OUTi_VALID after edge N (no flow-through when empty).
//   - Throughput: one push and one pop per output per cycle. Push+pop on a non-full, non-empty FIFO
//     leaves the count unchanged. When full, IN_READY=0 even if a pop is in progress (no same-cycle bypass).
//   - Ordering is FIFO within each output. There is no ordering guarantee between OUT0 and OUT1.
//   - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits, range 0..DEPTH.
//   - OUTi holds its value while OUTi_VALID && !OUTi_READY. When empty, OUTi shows the stale last entry (don't-care).
//   - Producer must hold IN/SEL stable while IN_VALID && !IN_READY. The block does not check this.
// CONFIGURATION
//   DEMUX_STATS_EN defined:
//     - STAT0/STAT1 increment on each push to FIFO 0/1.
//     - STALL_CNT increments each cycle IN_VALID && !IN_READY.
//     - All are 32-bit, wrap 0xFFFFFFFF->0, and reset to 0.
//   DEMUX_STATS_EN undefined: counters are not built; STAT0, STAT1, STALL_CNT are tied to 0 (ports kept).
// STRUCTURE
//   - Shared package proc_pkg: WORD_W=64, DEMUX_DEPTH=2, STAT_W=32, and clog2 helper function.
//   - Sub-module demux_fifo: one WIDTH x DEPTH synchronous FIFO with push/pop/full/empty/head.
//     It is instantiated twice; the top holds the SEL decode, IN_READY mux and stats.
// TESTING
//   1. Reset: assert RST_N=0 mid-stream with 2 words queued -> OUT0_VALID=OUT1_VALID=0 immediately;
//      after release IN_READY=1 and all stats=0.
//   2. Single route: push 0xDEADBEEF_00000001 with SEL=0, OUT0_READY=1 -> OUT0_VALID one cycle later
//      with that value; OUT1_VALID stays 0.
//   3. Backpressure: OUT1_READY=0, push 3 words with SEL=1 -> 2 accepted, IN_READY=0 on the 3rd.
//      Pushing SEL=0 in the same period still succeeds; STALL_CNT counts the blocked cycles.
//   4. Full-pop corner: FIFO1 full, OUT1_READY=1 and IN_VALID with SEL=1 on the same edge -> pop occurs,
//      push refused; the next cycle push accepted.
//   5. Wrap/order: stream 10 words alternating SEL with random OUTx_READY -> each output receives its
//      words in issue order and none are lost or duplicated; STAT0=5, STAT1=5 (stats build).
//   6. Stats off: build without DEMUX_STATS_EN, repeat test 5 -> identical data; STAT0/STAT1/STALL_CNT=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and helpers for the processor datapath blocks.
package proc_pkg;
  localparam int WORD_W      = 64;
  localparam int DEMUX_DEPTH = 2;
  localparam int STAT_W      = 32;

  typedef logic [STAT_W-1:0] stat_t;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/demux_fifo.sv
// Single WIDTH x DEPTH synchronous FIFO; head is registered storage, so there is no flow-through.
module demux_fifo
  import proc_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  // A one-entry FIFO still needs a 1-bit pointer to index storage.
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/demux_2_64bit_buf.sv
// Registered 1-to-2 demux with a FIFO per output; define DEMUX_STATS_EN to build the
// push/stall counters, otherwise stat0/stat1/stall_cnt read as zero.
module demux_2_64bit_buf
  import proc_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output stat_t            stat0,
  output stat_t            stat1,
  output stat_t            stall_cnt
);
  logic full0;
  logic full1;
  logic empty0;
  logic empty1;
  logic push0;
  logic push1;

  // Readiness depends only on the addressed FIFO, so a stalled path never blocks the other.
  assign in_ready   = sel ? !full1 : !full0;
  assign push0      = in_valid && in_ready && !sel;
  assign push1      = in_valid && in_ready &&  sel;
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .din   (in),
    .pop   (out0_ready),
    .head  (out0),
    .full  (full0),
    .empty (empty0)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .din   (in),
    .pop   (out1_ready),
    .head  (out1),
    .full  (full1),
    .empty (empty1)
  );

`ifdef DEMUX_STATS_EN
  stat_t stat0_q;
  stat_t stat1_q;
  stat_t stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
      stall_q <= '0;
    end else begin
      if (push0) stat0_q <= stat0_q + 1'b1;
      if (push1) stat1_q <= stat1_q + 1'b1;
      if (in_valid && !in_ready) stall_q <= stall_q + 1'b1;
    end
  end

  assign stat0     = stat0_q;
  assign stat1     = stat1_q;
  assign stall_cnt = stall_q;
`else
  assign stat0     = '0;
  assign stat1     = '0;
  assign stall_cnt = '0;
`endif
endmodule
